// File: rtl/hazard_detect.sv
// Decode-stage hazard unit: load-use stall, EX/MEM/WB forwarding selects, saturating stall counter.
// Optional build macro HAZARD_R0_FILTER_EN: source index 0 (hardwired R0) never matches a producer.
module hazard_detect #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       opCode,
    input  logic [REG_W-1:0] RS1,
    input  logic [REG_W-1:0] RS2,
    input  logic [REG_W-1:0] Rd2,
    input  logic [REG_W-1:0] Rd3,
    input  logic [REG_W-1:0] Rd4,
    input  logic             EX_RegWr,
    input  logic             MEM_RegWr,
    input  logic             WB_RegWr,
    input  logic             EX_MemRd,
    output logic             stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] stall_count
);

    logic             uses_rs1;
    logic             uses_rs2;
    logic             rs1_live;
    logic             rs2_live;
    logic [CNT_W-1:0] stall_count_d;
    logic [CNT_W-1:0] stall_count_q;

    // Youngest producer wins: EX, then MEM, then WB, else the register file.
    function automatic logic [1:0] fwd_sel(
        input logic             live,
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] ex_rd,
        input logic             ex_wr,
        input logic [REG_W-1:0] mem_rd,
        input logic             mem_wr,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (live && ex_wr && (ex_rd == src)) begin
            sel = 2'b01;
        end else if (live && mem_wr && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (live && wb_wr && (wb_rd == src)) begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (opCode)
            4'h0, 4'h1, 4'h2: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            4'h3, 4'h4, 4'h5, 4'h6, 4'hF: begin
                uses_rs1 = 1'b1;
            end
            4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            4'hC, 4'hD, 4'hE: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

`ifdef HAZARD_R0_FILTER_EN
    assign rs1_live = uses_rs1 && (RS1 != '0);
    assign rs2_live = uses_rs2 && (RS2 != '0);
`else
    assign rs1_live = uses_rs1;
    assign rs2_live = uses_rs2;
`endif

    always_comb begin
        ForwardA = fwd_sel(rs1_live, RS1, Rd2, EX_RegWr, Rd3, MEM_RegWr, Rd4, WB_RegWr);
        ForwardB = fwd_sel(rs2_live, RS2, Rd2, EX_RegWr, Rd3, MEM_RegWr, Rd4, WB_RegWr);
        stall    = EX_MemRd && EX_RegWr &&
                   ((rs1_live && (Rd2 == RS1)) || (rs2_live && (Rd2 == RS2)));
    end

    // Saturate at all-ones rather than wrapping so long runs stay meaningful.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_detect.sv
// Self-checking bench for hazard_detect: directed cases plus randomized stimulus against a table-driven model.
// Honours HAZARD_R0_FILTER_EN when the same macro is defined for the build.
module tb_hazard_detect;

    logic        clk;
    logic        reset;
    logic [3:0]  opCode;
    logic [2:0]  RS1;
    logic [2:0]  RS2;
    logic [2:0]  Rd2;
    logic [2:0]  Rd3;
    logic [2:0]  Rd4;
    logic        EX_RegWr;
    logic        MEM_RegWr;
    logic        WB_RegWr;
    logic        EX_MemRd;
    logic        stall;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [15:0] stall_count;

    int errorCount;
    int checkCount;
    int modelCount;

    hazard_detect #(.REG_W(3), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .opCode     (opCode),
        .RS1        (RS1),
        .RS2        (RS2),
        .Rd2        (Rd2),
        .Rd3        (Rd3),
        .Rd4        (Rd4),
        .EX_RegWr   (EX_RegWr),
        .MEM_RegWr  (MEM_RegWr),
        .WB_RegWr   (WB_RegWr),
        .EX_MemRd   (EX_MemRd),
        .stall      (stall),
        .ForwardA   (ForwardA),
        .ForwardB   (ForwardB),
        .stall_count(stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checkCount++;
        if (got !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expected, $time);
        end
    endtask

    // Which opcodes read each source, as bitmaps indexed by opcode.
    function automatic bit modelUses(input bit [3:0] op, input bit second);
        bit [15:0] map1;
        bit [15:0] map2;
        map1 = 16'h8FFF;
        map2 = 16'h0F87;
        return second ? map2[op] : map1[op];
    endfunction

    function automatic bit modelLive(input bit [3:0] op, input bit second, input bit [2:0] src);
        bit live;
        live = modelUses(op, second);
`ifdef HAZARD_R0_FILTER_EN
        if (src == 3'd0) live = 1'b0;
`endif
        return live;
    endfunction

    // Walk producers youngest-first; the first writer of the source wins.
    function automatic bit [1:0] modelForward(input bit live, input bit [2:0] src,
                                              input bit [2:0] d0, input bit w0,
                                              input bit [2:0] d1, input bit w1,
                                              input bit [2:0] d2, input bit w2);
        bit [2:0] dst [3];
        bit       wr  [3];
        dst[0] = d0; dst[1] = d1; dst[2] = d2;
        wr[0]  = w0; wr[1]  = w1; wr[2]  = w2;
        if (!live) return 2'b00;
        for (int i = 0; i < 3; i++) begin
            if (wr[i] && dst[i] == src) return 2'(i + 1);
        end
        return 2'b00;
    endfunction

    task automatic applyStimulus(input bit rst, input bit [3:0] op,
                                 input bit [2:0] s1, input bit [2:0] s2,
                                 input bit [2:0] d2, input bit [2:0] d3, input bit [2:0] d4,
                                 input bit exw, input bit memw, input bit wbw, input bit exrd);
        bit       live1;
        bit       live2;
        bit       expStall;
        bit [1:0] expA;
        bit [1:0] expB;
        reset = rst; opCode = op; RS1 = s1; RS2 = s2;
        Rd2 = d2; Rd3 = d3; Rd4 = d4;
        EX_RegWr = exw; MEM_RegWr = memw; WB_RegWr = wbw; EX_MemRd = exrd;
        live1    = modelLive(op, 1'b0, s1);
        live2    = modelLive(op, 1'b1, s2);
        expA     = modelForward(live1, s1, d2, exw, d3, memw, d4, wbw);
        expB     = modelForward(live2, s2, d2, exw, d3, memw, d4, wbw);
        expStall = exrd && exw && ((live1 && d2 == s1) || (live2 && d2 == s2));
        #1;
        checkOutput("stall", 32'(stall), 32'(expStall));
        checkOutput("ForwardA", 32'(ForwardA), 32'(expA));
        checkOutput("ForwardB", 32'(ForwardB), 32'(expB));
        @(posedge clk);
        #1;
        if (rst) modelCount = 0;
        else if (expStall && modelCount < 65535) modelCount++;
        checkOutput("stall_count", 32'(stall_count), 32'(modelCount));
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        modelCount = 0;
        reset = 1'b1; opCode = 4'h0; RS1 = 3'd0; RS2 = 3'd0;
        Rd2 = 3'd0; Rd3 = 3'd0; Rd4 = 3'd0;
        EX_RegWr = 1'b0; MEM_RegWr = 1'b0; WB_RegWr = 1'b0; EX_MemRd = 1'b0;
        @(posedge clk);
        #1;

        // reset
        applyStimulus(1, 4'h0, 3'd1, 3'd2, 3'd7, 3'd7, 3'd7, 0, 0, 0, 0);
        checkOutput("reset_count", 32'(stall_count), 32'd0);

        // EX to A, MEM to B
        applyStimulus(0, 4'h1, 3'd3, 3'd4, 3'd3, 3'd4, 3'd0, 1, 1, 0, 0);
        checkOutput("dir_fwdA_ex", 32'(ForwardA), 32'd1);
        checkOutput("dir_fwdB_ex", 32'(ForwardB), 32'd2);

        // EX priority over MEM and WB
        applyStimulus(0, 4'h0, 3'd5, 3'd1, 3'd5, 3'd5, 3'd5, 1, 1, 1, 0);
        checkOutput("dir_priority", 32'(ForwardA), 32'd1);

        // load-use then MEM forward
        applyStimulus(0, 4'h2, 3'd1, 3'd6, 3'd6, 3'd2, 3'd3, 1, 0, 0, 1);
        checkOutput("dir_loaduse_count", 32'(stall_count), 32'd1);
        applyStimulus(0, 4'h2, 3'd1, 3'd6, 3'd1, 3'd6, 3'd3, 0, 1, 0, 0);
        checkOutput("dir_after_load_fwdB", 32'(ForwardB), 32'd2);

        // jump: no sources
        applyStimulus(0, 4'hC, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 1, 1, 1, 1);
        checkOutput("dir_jmp_stall", 32'(stall), 32'd0);

        // WB-only forward on a store's data operand
        applyStimulus(0, 4'h7, 3'd1, 3'd4, 3'd2, 3'd3, 3'd4, 1, 1, 1, 0);
        checkOutput("dir_wb_fwdB", 32'(ForwardB), 32'd3);

        // R0 handling
        applyStimulus(0, 4'h3, 3'd0, 3'd5, 3'd0, 3'd1, 3'd1, 1, 0, 0, 1);
`ifdef HAZARD_R0_FILTER_EN
        checkOutput("dir_r0_fwdA", 32'(ForwardA), 32'd0);
        checkOutput("dir_r0_stall_count", 32'(stall_count), 32'd1);
`else
        checkOutput("dir_r0_fwdA", 32'(ForwardA), 32'd1);
        checkOutput("dir_r0_stall_count", 32'(stall_count), 32'd2);
`endif

        // reset, then 3 stall cycles
        applyStimulus(1, 4'h0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 4'h0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 1, 0, 0, 1);
        end
        checkOutput("dir_count3", 32'(stall_count), 32'd3);

        // drive the counter to saturation and beyond
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            if (modelCount < 65535) modelCount++;
        end
        #1;
        checkOutput("sat_count", 32'(stall_count), 32'hFFFF);
        applyStimulus(0, 4'h1, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 1, 0, 0, 1);
        checkOutput("sat_hold", 32'(stall_count), 32'hFFFF);
        applyStimulus(1, 4'h1, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 1, 0, 0, 1);
        checkOutput("sat_reset", 32'(stall_count), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
